uart_rx: RTL

//  UART receiver, 8N1 by default, LSB first, line idle high. Consumes the 16x-oversample
//  rx tick from the baud rate generator and recovers bytes by mid-bit sampling.

---
 rtl/uart_rx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, LSB first, valid/ready delivery with error pulses.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 parity_err_o
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
`endif
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d, data_q, data_d;
  logic                   valid_q, valid_d, deliver_q, deliver_d, par_bad_q, par_bad_d;
  logic                   ferr_q, ferr_d, ovr_q, ovr_d, perr_q, perr_d;
  logic                   rx_s, tick_end;
  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], rx_i};
  assign tick_end = rx_tick_i && tick_q == 4'd15;
  always_comb begin
    state_d   = state_q;
    tick_d    = rx_tick_i ? tick_q + 4'd1 : tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    ovr_d     = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q & ~ready_i;
    // A byte finished last cycle: accept it only if the output slot is free or draining now
    if (deliver_q) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else ovr_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        tick_d  = 4'd0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (rx_tick_i && tick_q == 4'd7) begin
        state_d = rx_s ? IDLE : DATA;
        tick_d  = 4'd0;
        bit_d   = 3'd0;
      end
      DATA: if (tick_end) begin
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_d = bit_q == 3'(DATA_BITS-1) ? PARITY : DATA;
`else
        state_d = bit_q == 3'(DATA_BITS-1) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick_end) begin
        par_bad_d = ^shift_q ^ rx_s;
        state_d   = STOP;
      end
`endif
      STOP: if (tick_end) begin
        state_d   = rx_s ? IDLE : BREAK;
        ferr_d    = ~rx_s;
        perr_d    = rx_s & par_bad_q;
        deliver_d = rx_s & ~par_bad_q;
      end
      BREAK: state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      deliver_q <= 1'b0;
      par_bad_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      deliver_q <= deliver_d;
      par_bad_q <= par_bad_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
    end
  end
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign parity_err_o = perr_q;
endmodule
